exu_alu_cmt_pipe: RTL

Producer side of the ALU-to-commit handshake: registers per-instruction results from the ALU and presents them to the commit stage on a valid/ready channel. A two-entry skid buffer keeps upstream ready registered, preserves order and sustains one instruction per cycle. It fences further instructions after an ebreak until commit raises the trap, and counts committed instructions.

---
 rtl/exu_alu_cmt_pipe.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/exu_alu_cmt_pipe.sv
// exu_alu_cmt_pipe
//   Producer side of the ALU-to-commit handshake. ALU results are registered into a
//   two-entry skid buffer (main + skid). The main entry drives the commit channel.
//   Upstream ready depends only on flops. An accepted ebreak fences further input
//   until commit flushes. Committed instructions are counted.
//
// Optional feature macro: EXU_CMT_EBREAK_FENCE_EN (enables the ebreak fence).
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   flush_i             commit trap; clears buffered entries and the fence
//   alu_i_*             ALU result channel (valid/ready plus fields)
//   alu_cmt_o_*         commit channel (valid/ready plus fields of the head entry)
//   fence_o             ebreak fence active
//   cmt_cnt             output beats since reset, wraps silently

`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module exu_alu_cmt_pipe #(
   parameter int unsigned PC_W    = `PC_SIZE,
   parameter int unsigned INSTR_W = `INSTR_SIZE,
   parameter int unsigned XLEN    = `XLEN
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush_i,
   input  logic               alu_i_valid,
   output logic               alu_i_ready,
   input  logic [PC_W-1:0]    alu_i_pc,
   input  logic [INSTR_W-1:0] alu_i_instr,
   input  logic               alu_i_pc_vld,
   input  logic [XLEN-1:0]    alu_i_imm,
   input  logic               alu_i_bjp,
   input  logic               alu_i_ebreak,
   input  logic               alu_i_bjp_prdt,
   input  logic               alu_i_ld,
   input  logic               alu_i_stamo,
   output logic               alu_cmt_o_valid,
   input  logic               alu_cmt_o_ready,
   output logic [PC_W-1:0]    alu_cmt_o_pc,
   output logic [INSTR_W-1:0] alu_cmt_o_instr,
   output logic               alu_cmt_o_pc_vld,
   output logic [XLEN-1:0]    alu_cmt_o_imm,
   output logic               alu_cmt_o_bjp,
   output logic               alu_cmt_o_ebreak,
   output logic               alu_cmt_o_bjp_prdt,
   output logic               alu_cmt_o_ld,
   output logic               alu_cmt_o_stamo,
   output logic               fence_o,
   output logic [XLEN-1:0]    cmt_cnt
);

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic               pc_vld;
      logic [XLEN-1:0]    imm;
      logic               bjp;
      logic               ebreak;
      logic               bjp_prdt;
      logic               ld;
      logic               stamo;
   } entry_t;

   entry_t            in_ent;
   entry_t            main_q, main_d;
   entry_t            skid_q, skid_d;
   logic              main_vld_q, main_vld_d;
   logic              skid_vld_q, skid_vld_d;
   logic [XLEN-1:0]   cnt_q, cnt_d;
   logic              fence;
   logic              in_beat;
   logic              out_beat;

   assign in_ent = '{pc: alu_i_pc, instr: alu_i_instr, pc_vld: alu_i_pc_vld, imm: alu_i_imm,
                     bjp: alu_i_bjp, ebreak: alu_i_ebreak, bjp_prdt: alu_i_bjp_prdt,
                     ld: alu_i_ld, stamo: alu_i_stamo};

   // Ready is a function of flops only, so it never depends on commit ready.
   assign alu_i_ready = ~skid_vld_q & ~fence;
   assign in_beat     = alu_i_valid & alu_i_ready;
   assign out_beat    = main_vld_q & alu_cmt_o_ready;

`ifdef EXU_CMT_EBREAK_FENCE_EN
   logic fence_q, fence_d;

   always_comb begin
      fence_d = fence_q | (in_beat & alu_i_ebreak);
      if (flush_i) begin
         fence_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fence_q <= 1'b0;
      end else begin
         fence_q <= fence_d;
      end
   end

   assign fence = fence_q;
`else
   assign fence = 1'b0;
`endif

   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      // An output beat in a flush cycle still completes, so the count is unconditional.
      cnt_d      = cnt_q + XLEN'(out_beat);
      if (flush_i) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (skid_vld_q) begin
         // Full: only draining is possible; skid moves up to keep order.
         if (out_beat) begin
            main_d     = skid_q;
            skid_vld_d = 1'b0;
         end
      end else if (main_vld_q) begin
         if (in_beat && out_beat) begin
            main_d = in_ent;
         end else if (in_beat) begin
            skid_d     = in_ent;
            skid_vld_d = 1'b1;
         end else if (out_beat) begin
            main_vld_d = 1'b0;
         end
      end else if (in_beat) begin
         main_d     = in_ent;
         main_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         cnt_q      <= cnt_d;
      end
   end

   assign alu_cmt_o_valid    = main_vld_q;
   assign alu_cmt_o_pc       = main_q.pc;
   assign alu_cmt_o_instr    = main_q.instr;
   assign alu_cmt_o_pc_vld   = main_q.pc_vld;
   assign alu_cmt_o_imm      = main_q.imm;
   assign alu_cmt_o_bjp      = main_q.bjp;
   assign alu_cmt_o_ebreak   = main_q.ebreak;
   assign alu_cmt_o_bjp_prdt = main_q.bjp_prdt;
   assign alu_cmt_o_ld       = main_q.ld;
   assign alu_cmt_o_stamo    = main_q.stamo;
   assign fence_o            = fence;
   assign cmt_cnt            = cnt_q;

endmodule
